// File: rtl/cache_top.sv
// rtl/cache_top.sv - direct-mapped write-through write-allocate cache with built-in backing memory
module cache_top #(
  parameter int LINES     = 8,
  parameter int MEM_WORDS = 256,
  parameter int MEM_LAT   = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] ADDR,
  input  logic [31:0] DIN,
  input  logic        WE,
  input  logic        RREQ,
  output logic [31:0] DOUT,
  output logic        RDY
);

  localparam int IW = $clog2(LINES);
  localparam int AW = $clog2(MEM_WORDS);
  localparam int TW = AW - IW;
  localparam int CW = $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {IDLE, LOOKUP, MISS_WAIT, WRITE_WAIT} state_t;

  state_t state, state_nxt;

  // latched request
  logic [AW-1:0] addr_q;
  logic [31:0]   din_q;
  logic          wr_q;
  logic [CW-1:0] cnt;

  // cache lines
  logic [LINES-1:0] line_valid;
  logic [TW-1:0]    line_tag  [LINES];
  logic [31:0]      line_data [LINES];

  // backing memory; a word never written reads back as its own address,
  // which gives the power-up image word i = i without clearing on reset
  logic [31:0]          mem [MEM_WORDS];
  logic [MEM_WORDS-1:0] mem_written = '0;

  logic [IW-1:0] idx;
  logic [TW-1:0] tag;
  logic          hit;
  logic [31:0]   mem_word;
  logic          cnt_last;

  // control strobes from the FSM
  logic accept, read_hit, fill, write_line, load_cnt, write_done;

  logic unused_addr_bits;
  assign unused_addr_bits = ^ADDR[31:AW];

  assign idx      = addr_q[IW-1:0];
  assign tag      = addr_q[AW-1:IW];
  assign hit      = line_valid[idx] && (line_tag[idx] == tag);
  assign mem_word = mem_written[addr_q] ? mem[addr_q] : 32'(addr_q);
  assign cnt_last = (cnt == CW'(1));

  // state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // next state and per-cycle control strobes
  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    read_hit   = 1'b0;
    fill       = 1'b0;
    write_line = 1'b0;
    load_cnt   = 1'b0;
    write_done = 1'b0;
    case (state)
      IDLE: begin
        if (RDY && (WE || RREQ)) begin
          accept    = 1'b1;
          state_nxt = LOOKUP;
        end
      end
      LOOKUP: begin
        if (wr_q) begin
          write_line = 1'b1;
          load_cnt   = 1'b1;
          state_nxt  = WRITE_WAIT;
        end else if (hit) begin
          read_hit  = 1'b1;
          state_nxt = IDLE;
        end else begin
          load_cnt  = 1'b1;
          state_nxt = MISS_WAIT;
        end
      end
      MISS_WAIT: begin
        if (cnt_last) begin
          fill      = 1'b1;
          state_nxt = IDLE;
        end
      end
      WRITE_WAIT: begin
        if (cnt_last) begin
          write_done = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // request latch, latency counter, valid bits and outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      addr_q     <= '0;
      din_q      <= '0;
      wr_q       <= 1'b0;
      cnt        <= '0;
      line_valid <= '0;
      DOUT       <= '0;
      RDY        <= 1'b1;
    end else begin
      if (accept) begin
        addr_q <= ADDR[AW-1:0];
        din_q  <= DIN;
        wr_q   <= WE;
        RDY    <= 1'b0;
      end
      if (load_cnt) begin
        cnt <= CW'(MEM_LAT);
      end else if (state == MISS_WAIT || state == WRITE_WAIT) begin
        cnt <= cnt - CW'(1);
      end
      if (read_hit) begin
        DOUT <= line_data[idx];
        RDY  <= 1'b1;
      end
      if (fill) begin
        DOUT            <= mem_word;
        RDY             <= 1'b1;
        line_valid[idx] <= 1'b1;
      end
      if (write_line) begin
        line_valid[idx] <= 1'b1;
      end
      if (write_done) begin
        RDY <= 1'b1;
      end
    end
  end

  // line tag/data and backing memory storage (not affected by reset)
  always_ff @(posedge CLK) begin
    if (fill) begin
      line_tag[idx]  <= tag;
      line_data[idx] <= mem_word;
    end
    if (write_line) begin
      line_tag[idx]       <= tag;
      line_data[idx]      <= din_q;
      mem[addr_q]         <= din_q;
      mem_written[addr_q] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cache_top.sv
// tb/tb_cache_top.sv - scoreboard bench for cache_top against a reference memory/cache model
module tb_cache_top;

  localparam int LINES     = 8;
  localparam int MEM_WORDS = 256;
  localparam int MEM_LAT   = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] ADDR;
  logic [31:0] DIN;
  logic        WE;
  logic        RREQ;
  logic [31:0] DOUT;
  logic        RDY;

  cache_top #(.LINES(LINES), .MEM_WORDS(MEM_WORDS), .MEM_LAT(MEM_LAT)) dut (
    .CLK(CLK), .RST(RST), .ADDR(ADDR), .DIN(DIN),
    .WE(WE), .RREQ(RREQ), .DOUT(DOUT), .RDY(RDY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit          is_read;
    int          addr;
    logic [31:0] dout;
    int          lat;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  // reference model: main memory contents, which word address each line holds
  logic [31:0] ref_mem [MEM_WORDS];
  int          ref_line [LINES];
  logic [31:0] ref_last;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < LINES; i++) ref_line[i] = -1;
    ref_last = 32'd0;
  endtask

  // compute the expected response of one request and queue it
  task automatic predict(input bit wr, input int addr, input logic [31:0] din);
    exp_t e;
    int a, ix;
    a  = addr & (MEM_WORDS - 1);
    ix = a % LINES;
    e.addr = a;
    if (wr) begin
      e.is_read    = 1'b0;
      e.lat        = 1 + MEM_LAT;
      e.dout       = ref_last;
      ref_mem[a]   = din;
      ref_line[ix] = a;
    end else begin
      e.is_read    = 1'b1;
      e.lat        = (ref_line[ix] == a) ? 1 : 1 + MEM_LAT;
      e.dout       = ref_mem[a];
      ref_last     = ref_mem[a];
      ref_line[ix] = a;
    end
    q.push_back(e);
  endtask

  // wait for idle, present a request for 'hold' rising edges, then drop it
  task automatic issue(input bit wr, input bit rd, input logic [31:0] addr,
                       input logic [31:0] din, input int hold);
    int n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!RDY && n < 100);
    total++;
    if (!RDY) begin
      bad++;
      $display("FAIL rdy_timeout: RDY=%b after %0d cycles, expected 1", RDY, n);
    end
    predict(wr, int'(addr), din);
    ADDR = addr;
    DIN  = din;
    WE   = wr;
    RREQ = rd;
    repeat (hold) @(posedge CLK);
    #1;
    WE   = 1'b0;
    RREQ = 1'b0;
  endtask

  task automatic rd(input int a);
    issue(1'b0, 1'b1, 32'(a), 32'd0, 1);
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    issue(1'b1, 1'b0, 32'(a), d, 1);
  endtask

  // monitor: measure each busy period and compare with the queued expectation
  int  low_cnt = 0;
  bit  busy    = 1'b0;
  always @(negedge CLK) begin
    if (RST) begin
      low_cnt = 0;
      busy    = 1'b0;
    end else if (!RDY) begin
      busy = 1'b1;
      low_cnt++;
    end else if (busy) begin
      exp_t e;
      busy = 1'b0;
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_response: got busy of %0d cycles, expected none", low_cnt);
      end else begin
        e = q.pop_front();
        check($sformatf("%s_latency@%0d", e.is_read ? "rd" : "wr", e.addr), 32'(low_cnt), 32'(e.lat));
        check($sformatf("%s_dout@%0d", e.is_read ? "rd" : "wr", e.addr), DOUT, e.dout);
      end
      low_cnt = 0;
    end
  end

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || busy || !RDY) && n < 200) begin
      @(negedge CLK);
      n++;
    end
    #1;
    check("drain_pending", 32'(q.size()), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = 32'(i);
    model_reset();
    ADDR = '0;
    DIN  = '0;
    WE   = 1'b0;
    RREQ = 1'b0;
    RST  = 1'b1;
    #100;
    @(negedge CLK);
    RST = 1'b0;
    check("reset_rdy", {31'd0, RDY}, 32'd1);
    check("reset_dout", DOUT, 32'd0);

    // first read misses, second hits
    rd(22);
    rd(22);
    drain();

    // write then read hit
    wr(22, 32'(-5942));
    rd(22);
    drain();
    check("neg_5942_const", ref_mem[22], 32'hFFFFE8CA);

    // conflict evictions
    for (int i = 0; i < 20; i++) rd(i);
    for (int i = 0; i < 10; i++) rd(i);
    drain();

    // write-through of negatives
    for (int i = 0; i < 10; i++) wr(i, 32'(-i));
    for (int i = 0; i < 10; i++) rd(i);
    drain();

    // repeated writes to one address
    for (int v = 0; v < 10; v++) wr(2, 32'(v));
    rd(2);
    drain();

    // reset in the middle of a read miss: aborted, lines invalidated, memory kept
    rd(15);
    repeat (2) @(posedge CLK);
    #2;
    RST = 1'b1;
    q.delete();
    model_reset();
    #20;
    @(negedge CLK);
    RST = 1'b0;
    check("midreset_rdy", {31'd0, RDY}, 32'd1);
    check("midreset_dout", DOUT, 32'd0);
    for (int i = 0; i < 10; i++) rd(i);
    drain();

    // WE and RREQ together act as a write
    issue(1'b1, 1'b1, 32'd5, 32'd77, 1);
    rd(5);
    drain();

    // request held across several busy cycles is accepted once
    issue(1'b0, 1'b1, 32'd100, 32'd0, 3);
    drain();

    // aliasing above MEM_WORDS
    rd(256 + 3);
    rd(3);
    drain();

    // randomized mix, addresses concentrated on a small window with random upper bits
    for (int k = 0; k < 300; k++) begin
      int op;
      logic [31:0] a;
      op = $urandom_range(0, 4);
      a  = ($urandom() & 32'hFFFF_FF00) | 32'($urandom_range(0, 31));
      if (op == 0)      issue(1'b1, 1'b0, a, $urandom(), 1);
      else if (op == 1) issue(1'b1, 1'b1, a, $urandom(), 1);
      else              issue(1'b0, 1'b1, a, 32'd0, 1);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
